exec_cc_mreg: RTL and testbench

//  Execute-stage back end, directly downstream of the 32-bit add/sub datapath.

---
 rtl/y86_pkg.sv | 60 ++++++
 rtl/exec_cc_mreg_if.sv | 40 ++++
 rtl/exec_cc_mreg_cond_eval.sv | 29 ++
 rtl/exec_cc_mreg.sv | 136 +++++++++++++
 tb/tb_exec_cc_mreg.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the execute back end: instruction codes, status
// codes, ALU/condition function codes, the "no register" ID and the
// condition-code register layout.
package y86_pkg;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOVXX = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_e;

    typedef enum logic [3:0] {
        A_ADD = 4'h0,
        A_SUB = 4'h1,
        A_AND = 4'h2,
        A_XOR = 4'h3
    } aluf_e;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_e;

    // Bit positions of the flags inside cc_t when viewed as a vector.
    localparam int unsigned CC_ZF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 0;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/exec_cc_mreg_if.sv
// E-stage operand/result bus into the execute back end and the E->M
// pipeline register contents coming out of it.
interface exec_cc_mreg_if #(
    parameter int W = 32
);
    // Execute-stage side
    logic [2:0]   e_stat;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic         alu_sub;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_s;
    logic         alu_co;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;

    // Memory-stage register side
    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    modport master (
        output e_stat, e_icode, e_ifun, alu_sub, alu_a, alu_b, alu_s, alu_co,
               e_valA, e_dstE, e_dstM,
        input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  e_stat, e_icode, e_ifun, alu_sub, alu_a, alu_b, alu_s, alu_co,
               e_valA, e_dstE, e_dstM,
        output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

endinterface

// File: rtl/exec_cc_mreg_cond_eval.sv
// Y86 jXX/cmovXX condition evaluation: condition codes + ifun -> cnd.
// Purely combinational; unknown condition codes (ifun > 6) evaluate false.
module exec_cond_eval
    import y86_pkg::*;
(
    input  cc_t        cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic lt;

    // Signed less-than comes from SF xor OF; table lookup on ifun.
    always_comb begin
        lt  = cc.sf ^ cc.of;
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | cc.zf;
            C_L:     cnd = lt;
            C_E:     cnd = cc.zf;
            C_NE:    cnd = ~cc.zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~cc.zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cc_mreg.sv
// Execute-stage back end: condition-code register, condition evaluation,
// cmov dstE squash and the E->M pipeline register with stall/bubble.
// Optional feature macro: EXEC_CARRY_FLAG_EN adds a carry flag (cc_cf).
module exec_cc_mreg
    import y86_pkg::*;
#(
    parameter int         W     = 32,
    parameter logic [3:0] RNONE = REG_NONE
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall_m,
    input  logic           bubble_m,
    input  logic           set_cc,
    input  logic           m_excp,
    exec_cc_mreg_if.slave  bus,
    output logic           e_cnd,
    output logic [3:0]     e_dstE_fwd,
    output logic           cc_zf,
    output logic           cc_sf,
`ifdef EXEC_CARRY_FLAG_EN
    output logic           cc_of,
    output logic           cc_cf
`else
    output logic           cc_of
`endif
);

    cc_t  cc_q;
    cc_t  cc_d;
    logic cc_we;
    logic is_add;
    logic is_sub;
    logic a_msb;
    logic b_msb;
    logic s_msb;

    assign a_msb = bus.alu_a[W-1];
    assign b_msb = bus.alu_b[W-1];
    assign s_msb = bus.alu_s[W-1];

    // Only the operand sign bits feed the flags.
    logic unused_ops;
    assign unused_ops = ^{bus.alu_a[W-2:0], bus.alu_b[W-2:0]};

    // CC is never updated behind a faulting older instruction or a bad E stat.
    assign cc_we = set_cc & ~m_excp & (bus.e_stat == S_AOK) & ~reset;

    // Next flag values from the ALU result; alu_sub overrides the ifun add case.
    always_comb begin
        is_sub  = bus.alu_sub;
        is_add  = ~bus.alu_sub & (bus.e_ifun == A_ADD);
        cc_d.zf = (bus.alu_s == '0);
        cc_d.sf = s_msb;
        cc_d.of = 1'b0;
        if (is_sub)
            cc_d.of = (a_msb != b_msb) & (s_msb != b_msb);
        else if (is_add)
            cc_d.of = (a_msb == b_msb) & (s_msb != a_msb);
    end

    // Condition-code register.
    always_ff @(posedge clk) begin
        if (reset)
            cc_q <= CC_RESET;
        else if (cc_we)
            cc_q <= cc_d;
    end

    assign cc_zf = cc_q.zf;
    assign cc_sf = cc_q.sf;
    assign cc_of = cc_q.of;

`ifdef EXEC_CARRY_FLAG_EN
    logic cf_q;
    logic cf_d;

    // Carry from the adder; subtraction reports borrow, logic ops clear it.
    always_comb begin
        cf_d = 1'b0;
        if (is_sub)
            cf_d = ~bus.alu_co;
        else if (is_add)
            cf_d = bus.alu_co;
    end

    // Carry flag register, written alongside the other flags.
    always_ff @(posedge clk) begin
        if (reset)
            cf_q <= 1'b0;
        else if (cc_we)
            cf_q <= cf_d;
    end

    assign cc_cf = cf_q;
`else
    logic unused_co;
    assign unused_co = bus.alu_co;
`endif

    // Condition is taken from the registered CC, before this cycle's write.
    exec_cond_eval u_cond (
        .cc   (cc_q),
        .ifun (bus.e_ifun),
        .cnd  (e_cnd)
    );

    // A cmov that fails its condition writes nothing.
    always_comb begin
        e_dstE_fwd = bus.e_dstE;
        if ((bus.e_icode == I_CMOVXX) && !e_cnd)
            e_dstE_fwd = RNONE;
    end

    // E->M register: reset > stall (hold) > bubble (nop) > load.
    always_ff @(posedge clk) begin
        if (reset || (!stall_m && bubble_m)) begin
            bus.M_stat  <= S_AOK;
            bus.M_icode <= I_NOP;
            bus.M_cnd   <= 1'b0;
            bus.M_valE  <= '0;
            bus.M_valA  <= '0;
            bus.M_dstE  <= RNONE;
            bus.M_dstM  <= RNONE;
        end else if (!stall_m) begin
            bus.M_stat  <= bus.e_stat;
            bus.M_icode <= bus.e_icode;
            bus.M_cnd   <= e_cnd;
            bus.M_valE  <= bus.alu_s;
            bus.M_valA  <= bus.e_valA;
            bus.M_dstE  <= e_dstE_fwd;
            bus.M_dstM  <= bus.e_dstM;
        end
    end

endmodule

// File: tb/tb_exec_cc_mreg.sv
// Self-checking bench for exec_cc_mreg: directed CC/condition vectors,
// hand sequences for stall/bubble/reset and CC inhibit, then random
// traffic against a reference model. Honours EXEC_CARRY_FLAG_EN.
module tb_exec_cc_mreg;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset, stall_m, bubble_m, set_cc, m_excp;
    logic e_cnd, cc_zf, cc_sf, cc_of;
    logic [3:0] e_dstE_fwd;
`ifdef EXEC_CARRY_FLAG_EN
    logic cc_cf;
`endif

    int checks = 0;
    int errors = 0;

    exec_cc_mreg_if #(.W(W)) bus ();

    exec_cc_mreg #(.W(W), .RNONE(4'hF)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_m    (stall_m),
        .bubble_m   (bubble_m),
        .set_cc     (set_cc),
        .m_excp     (m_excp),
        .bus        (bus),
        .e_cnd      (e_cnd),
        .e_dstE_fwd (e_dstE_fwd),
        .cc_zf      (cc_zf),
        .cc_sf      (cc_sf),
`ifdef EXEC_CARRY_FLAG_EN
        .cc_of      (cc_of),
        .cc_cf      (cc_cf)
`else
        .cc_of      (cc_of)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                           input logic sub, input logic [3:0] ifun, input logic co);
        bus.alu_a   = a;
        bus.alu_b   = b;
        bus.alu_s   = s;
        bus.alu_sub = sub;
        bus.e_ifun  = ifun;
        bus.alu_co  = co;
    endtask

    task automatic chk_m_nop(input string tag);
        chk({tag, "_stat"},  32'(bus.M_stat), 32'd1);
        chk({tag, "_icode"}, 32'(bus.M_icode), 32'd1);
        chk({tag, "_cnd"},   32'(bus.M_cnd), 32'd0);
        chk({tag, "_valE"},  bus.M_valE, 32'd0);
        chk({tag, "_valA"},  bus.M_valA, 32'd0);
        chk({tag, "_dstE"},  32'(bus.M_dstE), 32'hF);
        chk({tag, "_dstM"},  32'(bus.M_dstM), 32'hF);
    endtask

    typedef struct {
        logic [31:0] a, b, s;
        logic        sub;
        logic [3:0]  aluf;
        logic [3:0]  cond;
        logic        zf, sf, of, cnd;
    } vec_t;

    // Reference model state
    logic        m_zf, m_sf, m_of, m_cf;
    logic [2:0]  x_stat;
    logic [3:0]  x_icode, x_dstE, x_dstM;
    logic        x_cnd;
    logic [31:0] x_valE, x_valA;

    function automatic logic model_cnd(input logic [3:0] f, input logic zf, input logic sf, input logic of);
        logic lt;
        lt = (sf != of);
        case (f)
            4'd0: return 1'b1;
            4'd1: return lt || zf;
            4'd2: return lt;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !lt;
            4'd6: return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 4'd0, 4'd2, 0, 1, 1, 0};
        vecs[1]  = '{32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 4'd0, 4'd6, 0, 1, 1, 1};
        vecs[2]  = '{32'h5, 32'h5, 32'h0, 1'b1, 4'd1, 4'd3, 1, 0, 0, 1};
        vecs[3]  = '{32'h5, 32'h5, 32'h0, 1'b1, 4'd1, 4'd4, 1, 0, 0, 0};
        vecs[4]  = '{32'h5, 32'h3, 32'hFFFFFFFE, 1'b1, 4'd1, 4'd2, 0, 1, 0, 1};
        vecs[5]  = '{32'h5, 32'h3, 32'hFFFFFFFE, 1'b1, 4'd1, 4'd5, 0, 1, 0, 0};
        vecs[6]  = '{32'hF0, 32'h0F, 32'h0, 1'b0, 4'd2, 4'd1, 1, 0, 0, 1};
        vecs[7]  = '{32'h1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 4'd1, 4'd2, 0, 0, 1, 1};
        vecs[8]  = '{32'h1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 4'd1, 4'd7, 0, 0, 1, 0};
        vecs[9]  = '{32'h1, 32'h0, 32'h1, 1'b0, 4'd3, 4'd6, 0, 0, 0, 1};
        vecs[10] = '{32'h1, 32'h0, 32'h1, 1'b0, 4'd3, 4'd15, 0, 0, 0, 0};
        vecs[11] = '{32'h80000000, 32'h80000000, 32'h0, 1'b0, 4'd0, 4'd1, 1, 0, 1, 1};

        reset = 1'b1; stall_m = 1'b0; bubble_m = 1'b0; set_cc = 1'b0; m_excp = 1'b0;
        bus.e_stat = 3'd1; bus.e_icode = 4'h6; bus.e_valA = '0;
        bus.e_dstE = 4'h3; bus.e_dstM = 4'hF;
        set_alu(32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        tick(); tick();

        // 1: reset state
        chk("rst_zf", 32'(cc_zf), 32'd1);
        chk("rst_sf", 32'(cc_sf), 32'd0);
        chk("rst_of", 32'(cc_of), 32'd0);
`ifdef EXEC_CARRY_FLAG_EN
        chk("rst_cf", 32'(cc_cf), 32'd0);
`endif
        chk_m_nop("rst_m");
        reset = 1'b0;

        // 2/3: table of CC loads followed by a cmov condition check
        for (int unsigned i = 0; i < 12; i++) begin
            set_cc = 1'b1; bus.e_icode = 4'h6;
            set_alu(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].sub, vecs[i].aluf, 1'b0);
            tick();
            set_cc = 1'b0; bus.e_icode = 4'h2; bus.e_ifun = vecs[i].cond; bus.e_dstE = 4'h3;
            #1;
            chk($sformatf("v%0d_zf", i), 32'(cc_zf), 32'(vecs[i].zf));
            chk($sformatf("v%0d_sf", i), 32'(cc_sf), 32'(vecs[i].sf));
            chk($sformatf("v%0d_of", i), 32'(cc_of), 32'(vecs[i].of));
            chk($sformatf("v%0d_cnd", i), 32'(e_cnd), 32'(vecs[i].cnd));
            chk($sformatf("v%0d_fwd", i), 32'(e_dstE_fwd), vecs[i].cnd ? 32'h3 : 32'hF);
        end

        // 4: CC update inhibited by m_excp and by non-AOK stat
        bus.e_icode = 4'h6; set_cc = 1'b1;
        set_alu(32'h1, 32'h2, 32'h3, 1'b0, 4'h0, 1'b0);
        tick();
        chk("inh_base_zf", 32'(cc_zf), 32'd0);
        m_excp = 1'b1;
        set_alu(32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        tick();
        chk("inh_excp_zf", 32'(cc_zf), 32'd0);
        m_excp = 1'b0; bus.e_stat = 3'd3;
        tick();
        chk("inh_adr_zf", 32'(cc_zf), 32'd0);
        bus.e_stat = 3'd1;
        tick();
        chk("inh_ok_zf", 32'(cc_zf), 32'd1);
        set_cc = 1'b0;

        // 5: stall+bubble holds, bubble alone -> nop, reset during stall -> nop
        bus.e_icode = 4'h6; bus.e_ifun = 4'h0; bus.alu_s = 32'hABCD1234;
        bus.e_valA = 32'h55AA55AA; bus.e_dstE = 4'h7; bus.e_dstM = 4'h2;
        tick();
        chk("ld_valE", bus.M_valE, 32'hABCD1234);
        chk("ld_dstE", 32'(bus.M_dstE), 32'h7);
        stall_m = 1'b1; bubble_m = 1'b1;
        bus.alu_s = 32'h11111111; bus.e_icode = 4'h3; bus.e_dstE = 4'h1;
        tick(); tick();
        chk("stall_valE", bus.M_valE, 32'hABCD1234);
        chk("stall_icode", 32'(bus.M_icode), 32'h6);
        chk("stall_valA", bus.M_valA, 32'h55AA55AA);
        chk("stall_dstM", 32'(bus.M_dstM), 32'h2);
        stall_m = 1'b0;
        tick();
        chk_m_nop("bub_m");
        bubble_m = 1'b0;
        tick();
        chk("reld_valE", bus.M_valE, 32'h11111111);
        stall_m = 1'b1; reset = 1'b1;
        tick();
        chk_m_nop("rstall_m");
        chk("rstall_zf", 32'(cc_zf), 32'd1);
        reset = 1'b0; stall_m = 1'b0;

`ifdef EXEC_CARRY_FLAG_EN
        // 6: carry flag on add and borrow on sub
        set_cc = 1'b1; bus.e_icode = 4'h6;
        set_alu(32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'h0, 1'b1);
        tick();
        chk("cf_add", 32'(cc_cf), 32'd1);
        chk("cf_add_zf", 32'(cc_zf), 32'd1);
        set_alu(32'h1, 32'h3, 32'h2, 1'b1, 4'h1, 1'b1);
        tick();
        chk("cf_sub", 32'(cc_cf), 32'd0);
        set_alu(32'h3, 32'h1, 32'hFFFFFFFE, 1'b1, 4'h1, 1'b0);
        tick();
        chk("cf_borrow", 32'(cc_cf), 32'd1);
        set_alu(32'hFF, 32'hFF, 32'hFF, 1'b0, 4'h2, 1'b1);
        tick();
        chk("cf_logic", 32'(cc_cf), 32'd0);
        set_cc = 1'b0;
`endif

        // Random traffic against the model; resync model with a reset first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_zf = 1; m_sf = 0; m_of = 0; m_cf = 0;
        x_stat = 3'd1; x_icode = 4'h1; x_cnd = 0; x_valE = 0; x_valA = 0;
        x_dstE = 4'hF; x_dstM = 4'hF;
        for (int unsigned n = 0; n < 400; n++) begin
            logic [31:0] a, b, s;
            logic [3:0]  f;
            logic        sub, co, exp_cnd, is_add, we;
            logic [3:0]  exp_fwd;
            longint      r;
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                0: a = b;
                1: a = 32'h0;
                2: b = 32'h80000000 | a;
                default: ;
            endcase
            f = 4'($urandom_range(0, 15));
            sub = (f == 4'd1);
            is_add = (f == 4'd0);
            if (is_add) begin
                {co, s} = 33'(a) + 33'(b);
            end else if (sub) begin
                s = b - a; co = (b >= a);
            end else begin
                s = (f[0]) ? (a ^ b) : (a & b); co = $urandom_range(0, 1) != 0;
            end
            reset    = ($urandom_range(0, 39) == 0);
            stall_m  = ($urandom_range(0, 4) == 0);
            bubble_m = ($urandom_range(0, 4) == 0);
            set_cc   = ($urandom_range(0, 2) != 0);
            m_excp   = ($urandom_range(0, 7) == 0);
            bus.e_stat  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            bus.e_icode = ($urandom_range(0, 1) != 0) ? 4'h2 : 4'($urandom_range(0, 11));
            bus.e_valA  = $urandom;
            bus.e_dstE  = 4'($urandom_range(0, 15));
            bus.e_dstM  = 4'($urandom_range(0, 15));
            set_alu(a, b, s, sub, f, co);
            #1;
            exp_cnd = model_cnd(f, m_zf, m_sf, m_of);
            exp_fwd = (bus.e_icode == 4'h2 && !exp_cnd) ? 4'hF : bus.e_dstE;
            chk("rnd_cnd", 32'(e_cnd), 32'(exp_cnd));
            chk("rnd_fwd", 32'(e_dstE_fwd), 32'(exp_fwd));
            we = set_cc && !m_excp && bus.e_stat == 3'd1 && !reset;
            if (reset) begin
                m_zf = 1; m_sf = 0; m_of = 0; m_cf = 0;
            end else if (we) begin
                m_zf = (s == 0);
                m_sf = s[31];
                if (is_add)   r = longint'($signed(a)) + longint'($signed(b));
                else if (sub) r = longint'($signed(b)) - longint'($signed(a));
                else          r = 0;
                m_of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                m_cf = is_add ? co : (sub ? (b < a) : 1'b0);
            end
            if (reset || (!stall_m && bubble_m)) begin
                x_stat = 3'd1; x_icode = 4'h1; x_cnd = 0; x_valE = 0; x_valA = 0;
                x_dstE = 4'hF; x_dstM = 4'hF;
            end else if (!stall_m) begin
                x_stat = bus.e_stat; x_icode = bus.e_icode; x_cnd = exp_cnd;
                x_valE = s; x_valA = bus.e_valA; x_dstE = exp_fwd; x_dstM = bus.e_dstM;
            end
            tick();
            chk("rnd_zf", 32'(cc_zf), 32'(m_zf));
            chk("rnd_sf", 32'(cc_sf), 32'(m_sf));
            chk("rnd_of", 32'(cc_of), 32'(m_of));
`ifdef EXEC_CARRY_FLAG_EN
            chk("rnd_cf", 32'(cc_cf), 32'(m_cf));
`endif
            chk("rnd_Mstat", 32'(bus.M_stat), 32'(x_stat));
            chk("rnd_Micode", 32'(bus.M_icode), 32'(x_icode));
            chk("rnd_Mcnd", 32'(bus.M_cnd), 32'(x_cnd));
            chk("rnd_MvalE", bus.M_valE, x_valE);
            chk("rnd_MvalA", bus.M_valA, x_valA);
            chk("rnd_MdstE", 32'(bus.M_dstE), 32'(x_dstE));
            chk("rnd_MdstM", 32'(bus.M_dstM), 32'(x_dstM));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
